// File: rtl/midi_uart_tx.sv
// MIDI transmitter: sends 1-3 byte messages as 8N1 UART frames (LSB first, line idles high).
// Optional macro RUNNING_STATUS_EN: do not resend a channel status byte that matches the previous one.
module midi_uart_tx #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 31250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [6:0] msg_data1,
    input  logic [6:0] msg_data2,
    input  logic [1:0] msg_len,
    output logic       midi_out,
    output logic       busy,
    output logic       byte_done
);
    localparam int BIT_DIV = CLK_HZ / BAUD;
    localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          line_reg, line_next;
    logic          done_reg, done_next;
    logic [1:0]    remain_reg, remain_next;
    logic [7:0]    byte_reg [3];
    logic [7:0]    byte_next [3];
    logic          skip_status;
    logic          bit_end;

`ifdef RUNNING_STATUS_EN
    logic [7:0] last_status_reg, last_status_next;
    logic       is_channel, is_system_common;

    always_comb begin
        is_channel       = msg_status[7] && (msg_status[7:4] != 4'hF);
        is_system_common = (msg_status[7:3] == 5'b11110);
        skip_status      = is_channel && (msg_status == last_status_reg);
        last_status_next = last_status_reg;
        // Realtime and data-range status values leave the running status untouched
        if (msg_valid && (state_reg == IDLE)) begin
            if (is_channel)
                last_status_next = msg_status;
            else if (is_system_common)
                last_status_next = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_status_reg <= 8'h00;
        else
            last_status_reg <= last_status_next;
    end
`else
    assign skip_status = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        line_next   = line_reg;
        done_next   = 1'b0;
        remain_next = remain_reg;
        byte_next   = byte_reg;
        bit_end     = (baud_reg == BAUD_LAST);
        case (state_reg)
            IDLE: begin
                if (msg_valid) begin
                    state_next = LOAD;
                    if (skip_status) begin
                        byte_next[0] = {1'b0, msg_data1};
                        byte_next[1] = {1'b0, msg_data2};
                        byte_next[2] = 8'h00;
                        remain_next  = (msg_len == 2'd0) ? 2'd0 : msg_len - 2'd1;
                    end else begin
                        byte_next[0] = msg_status;
                        byte_next[1] = {1'b0, msg_data1};
                        byte_next[2] = {1'b0, msg_data2};
                        remain_next  = msg_len;
                    end
                end
            end
            LOAD: begin
                if (remain_reg == 2'd0) begin
                    state_next = IDLE;
                end else begin
                    // Pop the byte queue; the start bit is driven from the next cycle on
                    shift_next   = byte_reg[0];
                    byte_next[0] = byte_reg[1];
                    byte_next[1] = byte_reg[2];
                    remain_next  = remain_reg - 2'd1;
                    baud_next    = '0;
                    line_next    = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    line_next  = shift_reg[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        line_next  = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        line_next  = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next  = '0;
                    done_next  = 1'b1;
                    state_next = (remain_reg == 2'd0) ? IDLE : LOAD;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= 3'd0;
            shift_reg  <= 8'h00;
            line_reg   <= 1'b1;
            done_reg   <= 1'b0;
            remain_reg <= 2'd0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            line_reg   <= line_next;
            done_reg   <= done_next;
            remain_reg <= remain_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_byte_buf
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    byte_reg[gi] <= 8'h00;
                else
                    byte_reg[gi] <= byte_next[gi];
            end
        end
    endgenerate

    assign midi_out  = line_reg;
    assign msg_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign byte_done = done_reg;
endmodule
